rob_queue: RTL and testbench
============================

Name: rob_queue

Overview:
- Circular reorder buffer for the out-of-order RV32I core.
- Allocates entries in program order at dispatch and marks them complete from CDB writeback.
- Presents the head entry to the commit stage as rob_valid/rob_ready/commit_opcode and consumes rob_pop from it.
- Clears all in-flight entries on a pipeline flush.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- PREG_W, 6, physical register tag width.
- IDX_W, $clog2(DEPTH), entry index width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dispatch_valid  in  1  allocate one entry this cycle.
- dispatch_opcode  in  7  RV32I opcode of the dispatched instruction.
- dispatch_rd  in  5  architectural destination.
- dispatch_pd  in  PREG_W  physical destination tag.
- dispatch_ready  out  1  entry available (not full).
- dispatch_idx  out  IDX_W  index given to the instruction allocated this cycle (tail).
- cdb_valid  in  1  writeback strobe.
- cdb_idx  in  IDX_W  ROB index completing.
- cdb_mispredict  in  1  completing branch/jump resolved mispredicted.
- cdb_target  in  32  correct next PC for a mispredicted entry.
- rob_pop  in  1  commit retires the head this cycle.
- flush  in  1  discard every entry.
- rob_valid  out  1  head entry occupied.
- rob_ready  out  1  head entry completed.
- commit_opcode  out  7  head opcode.
- commit_rd  out  5  head architectural destination.
- commit_pd  out  PREG_W  head physical destination.
- flush_branch  out  1  head is completed and mispredicted.
- commit_target  out  32  head redirect PC.

Behaviour:
- Storage:
  - Per-entry fields: opcode, rd, pd, done, mispredict, target.
  - Head and tail pointers are IDX_W+1 bits; the MSB is the wrap bit.
  - empty = pointers equal; full = index bits equal and wrap bits differ.
- Reset (asynchronous):
  - head = tail = 0; all done and mispredict bits = 0.
  - Therefore rob_valid = 0, rob_ready = 0, flush_branch = 0, dispatch_ready = 1.
  - Payload outputs are 0 after reset.
- Combinational outputs:
  - dispatch_ready = !full.
  - dispatch_idx = tail[IDX_W-1:0].
  - rob_valid = !empty.
  - rob_ready = rob_valid && done[head].
  - flush_branch = rob_ready && mispredict[head].
  - commit_* fields read the head entry. They are don't-care when rob_valid = 0.
- Allocate:
  - Occurs when dispatch_valid && dispatch_ready.
  - Writes the payload, clears done and mispredict, and increments tail.
  - dispatch_valid while full is ignored; no state change.
  - Full blocks allocation even if rob_pop is asserted that cycle (no same-cycle reuse).
- Writeback:
  - Occurs when cdb_valid.
  - Sets done[cdb_idx]; mispredict[cdb_idx] = cdb_mispredict; target[cdb_idx] = cdb_target.
  - The result is visible on rob_ready the next cycle (1-cycle latency, no bypass).
  - Writeback to an unallocated index is illegal; it is flagged by an assertion and not tolerated.
- Pop:
  - Occurs when rob_pop && rob_ready; clears done and mispredict of the head and increments head.
  - rob_pop without rob_ready is ignored.
- Simultaneous events:
  - Allocate and pop in the same cycle are both performed; occupancy is unchanged.
  - Writeback in the same cycle as allocation of the same index cannot occur (the index is free). If it does, allocation wins.
- Flush:
  - Flush has priority over everything in the same cycle.
  - It sets head = tail = 0 and clears all done and mispredict bits.
  - Allocate, writeback and pop in that cycle are discarded.
  - The commit stage asserts flush in the same cycle as rob_pop of the mispredicted head. That pop is architecturally performed; the ROB simply empties.
- Wrap-around: pointer increments wrap modulo 2*DEPTH; index bits wrap modulo DEPTH.
- Reset asserted mid-operation clears state immediately, independent of clk.

Decomposition:
- rv32i_types package:
  - existing opcode constants (jal_opcode, jalr_opcode, br_opcode, store_opcode);
  - new rob_entry_t struct (opcode, rd, pd, done, mispredict, target);
  - ROB_DEPTH default constant.
- One sub-module, rob_ptr: a wrapping IDX_W+1 pointer register with increment and clear. Instantiated twice, for head and tail.

Test Plan:
- Reset then idle → rob_valid = 0, rob_ready = 0, flush_branch = 0, dispatch_ready = 1, dispatch_idx = 0.
- Dispatch 3 entries (opcodes 0x33, 0x63, 0x23), writeback idx 1 then idx 0:
  - rob_ready = 1 the cycle after idx 0 completes.
  - Pop twice → head advances to 2; rob_ready = 0 until idx 2 is written.
- Fill DEPTH = 16 entries → dispatch_ready = 0; a 17th dispatch_valid is ignored. Pop one → dispatch_ready = 1 next cycle and dispatch_idx = 0 (wrap).
- Steady state with allocate and pop every cycle for 40 cycles (entries pre-completed) → occupancy constant; pointers wrap twice; no lost or duplicated entries.
- Branch at head, writeback with mispredict = 1 and target 0x8000_0040 → next cycle flush_branch = 1, commit_target = 0x8000_0040. Pop plus flush → ROB empty and dispatch_idx = 0.
- Assert rst asynchronously mid-run with 5 entries in flight → outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types for the out-of-order core.
// Holds the opcode constants used by the front end and commit logic, the
// reorder-buffer entry layout and the default ROB depth.
package rv32i_types;

    localparam logic [6:0] jal_opcode   = 7'b1101111;
    localparam logic [6:0] jalr_opcode  = 7'b1100111;
    localparam logic [6:0] br_opcode    = 7'b1100011;
    localparam logic [6:0] store_opcode = 7'b0100011;

    localparam int unsigned ROB_DEPTH = 16;

    // Widest physical tag an entry can hold; narrower tags are zero-extended.
    localparam int unsigned PREG_W_MAX = 8;

    typedef struct packed {
        logic [6:0]            opcode;
        logic [4:0]            rd;
        logic [PREG_W_MAX-1:0] pd;
        logic                  done;
        logic                  mispredict;
        logic [31:0]           target;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ROB pointer: IDX_W index bits plus one wrap bit.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (pointer to 0)
//   clr_i  synchronous clear to 0, wins over inc_i
//   inc_i  advance by one, wrapping modulo 2*2^IDX_W
//   ptr_o  current pointer value
module rob_ptr #(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W:0]   ptr_o
);

    logic [IDX_W:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + (IDX_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_queue.sv
// Circular reorder buffer for the out-of-order RV32I core.
// Entries are allocated in program order at dispatch, marked complete by CDB
// writeback and retired from the head by the commit stage. Flush empties it.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   dispatch_valid/_opcode/_rd/_pd allocation request and payload
//   dispatch_ready, dispatch_idx  not full, index handed to the new entry
//   cdb_valid/_idx/_mispredict/_target  writeback of a completing entry
//   rob_pop, flush                retire head, discard everything
//   rob_valid, rob_ready          head occupied, head completed
//   commit_opcode/_rd/_pd/_target head payload
//   flush_branch                  head completed and mispredicted
module rob_queue
    import rv32i_types::*;
#(
    parameter int unsigned  DEPTH  = ROB_DEPTH,
    parameter int unsigned  PREG_W = 6,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_valid,
    input  logic [6:0]        dispatch_opcode,
    input  logic [4:0]        dispatch_rd,
    input  logic [PREG_W-1:0] dispatch_pd,
    output logic              dispatch_ready,
    output logic [IDX_W-1:0]  dispatch_idx,
    input  logic              cdb_valid,
    input  logic [IDX_W-1:0]  cdb_idx,
    input  logic              cdb_mispredict,
    input  logic [31:0]       cdb_target,
    input  logic              rob_pop,
    input  logic              flush,
    output logic              rob_valid,
    output logic              rob_ready,
    output logic [6:0]        commit_opcode,
    output logic [4:0]        commit_rd,
    output logic [PREG_W-1:0] commit_pd,
    output logic              flush_branch,
    output logic [31:0]       commit_target
);

    logic [IDX_W:0]   head_q, tail_q;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             empty, full, alloc, pop;
    rob_entry_t       entries_q [DEPTH];
    rob_entry_t       entries_d [DEPTH];
    rob_entry_t       head_entry;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    // Full blocks allocation even when the head retires this cycle.
    assign alloc    = dispatch_valid && !full;
    assign pop      = rob_pop && rob_ready;

    rob_ptr #(.IDX_W(IDX_W)) u_head (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (head_q)
    );

    rob_ptr #(.IDX_W(IDX_W)) u_tail (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (flush),
        .inc_i (alloc),
        .ptr_o (tail_q)
    );

    // Later assignments win: allocation overrides a stray writeback to the tail.
    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_d[i].done       = 1'b0;
                entries_d[i].mispredict = 1'b0;
            end
        end else begin
            if (cdb_valid) begin
                entries_d[cdb_idx].done       = 1'b1;
                entries_d[cdb_idx].mispredict = cdb_mispredict;
                entries_d[cdb_idx].target     = cdb_target;
            end
            if (pop) begin
                entries_d[head_idx].done       = 1'b0;
                entries_d[head_idx].mispredict = 1'b0;
            end
            if (alloc) begin
                entries_d[tail_idx].opcode     = dispatch_opcode;
                entries_d[tail_idx].rd         = dispatch_rd;
                entries_d[tail_idx].pd         = PREG_W_MAX'(dispatch_pd);
                entries_d[tail_idx].done       = 1'b0;
                entries_d[tail_idx].mispredict = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    assign head_entry     = entries_q[head_idx];
    assign dispatch_ready = !full;
    assign dispatch_idx   = tail_idx;
    assign rob_valid      = !empty;
    assign rob_ready      = rob_valid && head_entry.done;
    assign flush_branch   = rob_ready && head_entry.mispredict;
    assign commit_opcode  = head_entry.opcode;
    assign commit_rd      = head_entry.rd;
    assign commit_pd      = PREG_W'(head_entry.pd);
    assign commit_target  = head_entry.target;

    // An index is in flight when its distance from head is below occupancy.
    logic [IDX_W:0]   occupancy;
    logic [IDX_W-1:0] cdb_off;
    logic             cdb_in_flight;

    assign occupancy     = tail_q - head_q;
    assign cdb_off       = cdb_idx - head_idx;
    assign cdb_in_flight = ({1'b0, cdb_off} < occupancy);

    cdb_alloc_a: assert property (@(posedge clk) disable iff (rst) cdb_valid |-> cdb_in_flight)
        else $error("cdb writeback to unallocated ROB index %0d", cdb_idx);

endmodule

// File: tb/tb_rob_queue.sv
module tb_rob_queue;

    logic        clk;
    logic        rst;
    logic        dispatch_valid;
    logic [6:0]  dispatch_opcode;
    logic [4:0]  dispatch_rd;
    logic [5:0]  dispatch_pd;
    logic        dispatch_ready;
    logic [3:0]  dispatch_idx;
    logic        cdb_valid;
    logic [3:0]  cdb_idx;
    logic        cdb_mispredict;
    logic [31:0] cdb_target;
    logic        rob_pop;
    logic        flush;
    logic        rob_valid;
    logic        rob_ready;
    logic [6:0]  commit_opcode;
    logic [4:0]  commit_rd;
    logic [5:0]  commit_pd;
    logic        flush_branch;
    logic [31:0] commit_target;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [6:0] exp_q [$];

    rob_queue #(.DEPTH(16), .PREG_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .dispatch_valid  (dispatch_valid),
        .dispatch_opcode (dispatch_opcode),
        .dispatch_rd     (dispatch_rd),
        .dispatch_pd     (dispatch_pd),
        .dispatch_ready  (dispatch_ready),
        .dispatch_idx    (dispatch_idx),
        .cdb_valid       (cdb_valid),
        .cdb_idx         (cdb_idx),
        .cdb_mispredict  (cdb_mispredict),
        .cdb_target      (cdb_target),
        .rob_pop         (rob_pop),
        .flush           (flush),
        .rob_valid       (rob_valid),
        .rob_ready       (rob_ready),
        .commit_opcode   (commit_opcode),
        .commit_rd       (commit_rd),
        .commit_pd       (commit_pd),
        .flush_branch    (flush_branch),
        .commit_target   (commit_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid  = 1'b0;
        dispatch_opcode = '0;
        dispatch_rd     = '0;
        dispatch_pd     = '0;
        cdb_valid       = 1'b0;
        cdb_idx         = '0;
        cdb_mispredict  = 1'b0;
        cdb_target      = '0;
        rob_pop         = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic do_dispatch(input logic [6:0] op, input logic [4:0] rd, input logic [5:0] pd);
        dispatch_valid  = 1'b1;
        dispatch_opcode = op;
        dispatch_rd     = rd;
        dispatch_pd     = pd;
        tick();
        dispatch_valid  = 1'b0;
    endtask

    task automatic do_wb(input logic [3:0] idx, input logic misp, input logic [31:0] tgt);
        cdb_valid      = 1'b1;
        cdb_idx        = idx;
        cdb_mispredict = misp;
        cdb_target     = tgt;
        tick();
        cdb_valid      = 1'b0;
        cdb_mispredict = 1'b0;
    endtask

    task automatic do_pop();
        rob_pop = 1'b1;
        tick();
        rob_pop = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (rob_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rob_valid: got %b want 0", rob_valid); end
        n_cmp++; if (rob_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_rob_ready: got %b want 0", rob_ready); end
        n_cmp++; if (flush_branch !== 1'b0) begin n_fail++;
            $display("FAIL reset_flush_branch: got %b want 0", flush_branch); end
        n_cmp++; if (dispatch_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_dispatch_ready: got %b want 1", dispatch_ready); end
        n_cmp++; if (dispatch_idx !== 4'd0) begin n_fail++;
            $display("FAIL reset_dispatch_idx: got %0d want 0", dispatch_idx); end
        n_cmp++; if (commit_opcode !== 7'h00 || commit_target !== 32'h0) begin n_fail++;
            $display("FAIL reset_payload: got op %h tgt %h want 0 0", commit_opcode, commit_target); end
    endtask

    task automatic test_basic();
        n_cmp++; if (dispatch_idx !== 4'd0) begin n_fail++;
            $display("FAIL basic_idx0: got %0d want 0", dispatch_idx); end
        do_dispatch(7'h33, 5'd1, 6'd10);
        n_cmp++; if (dispatch_idx !== 4'd1) begin n_fail++;
            $display("FAIL basic_idx1: got %0d want 1", dispatch_idx); end
        do_dispatch(7'h63, 5'd2, 6'd11);
        n_cmp++; if (dispatch_idx !== 4'd2) begin n_fail++;
            $display("FAIL basic_idx2: got %0d want 2", dispatch_idx); end
        do_dispatch(7'h23, 5'd3, 6'd12);
        n_cmp++; if (rob_valid !== 1'b1 || rob_ready !== 1'b0 || commit_opcode !== 7'h33) begin
            n_fail++;
            $display("FAIL basic_head: got v%b r%b op %h want v1 r0 op 33",
                     rob_valid, rob_ready, commit_opcode); end
        do_wb(4'd1, 1'b0, 32'h0);
        n_cmp++; if (rob_ready !== 1'b0) begin n_fail++;
            $display("FAIL basic_wb1_not_head: got %b want 0", rob_ready); end
        do_wb(4'd0, 1'b0, 32'h0);
        n_cmp++; if (rob_ready !== 1'b1) begin n_fail++;
            $display("FAIL basic_wb0_ready: got %b want 1", rob_ready); end
        n_cmp++; if (commit_rd !== 5'd1 || commit_pd !== 6'd10) begin n_fail++;
            $display("FAIL basic_head_regs: got rd %0d pd %0d want 1 10", commit_rd, commit_pd); end
        do_pop();
        n_cmp++; if (commit_opcode !== 7'h63 || rob_ready !== 1'b1) begin n_fail++;
            $display("FAIL basic_pop1: got op %h r%b want 63 r1", commit_opcode, rob_ready); end
        do_pop();
        n_cmp++; if (commit_opcode !== 7'h23 || rob_valid !== 1'b1 || rob_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop2: got op %h v%b r%b want 23 v1 r0",
                     commit_opcode, rob_valid, rob_ready); end
        // Pop without a completed head must be ignored.
        do_pop();
        n_cmp++; if (commit_opcode !== 7'h23 || rob_valid !== 1'b1) begin n_fail++;
            $display("FAIL basic_pop_unready: got op %h v%b want 23 v1", commit_opcode, rob_valid); end
        do_wb(4'd2, 1'b0, 32'h0);
        n_cmp++; if (rob_ready !== 1'b1) begin n_fail++;
            $display("FAIL basic_wb2_ready: got %b want 1", rob_ready); end
        do_pop();
        n_cmp++; if (rob_valid !== 1'b0 || dispatch_idx !== 4'd3) begin n_fail++;
            $display("FAIL basic_drain: got v%b idx %0d want v0 idx 3", rob_valid, dispatch_idx); end
    endtask

    task automatic test_full();
        do_flush();
        n_cmp++; if (dispatch_idx !== 4'd0 || rob_valid !== 1'b0) begin n_fail++;
            $display("FAIL full_flush: got idx %0d v%b want 0 v0", dispatch_idx, rob_valid); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (dispatch_idx !== 4'(i) || dispatch_ready !== 1'b1) begin n_fail++;
                $display("FAIL full_fill_%0d: got idx %0d rdy %b want idx %0d rdy 1",
                         i, dispatch_idx, dispatch_ready, i); end
            do_dispatch(7'(8'h10 + i), 5'(i), 6'(i));
        end
        n_cmp++; if (dispatch_ready !== 1'b0 || dispatch_idx !== 4'd0 || rob_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state: got rdy %b idx %0d v%b want rdy 0 idx 0 v1",
                     dispatch_ready, dispatch_idx, rob_valid); end
        do_dispatch(7'h7f, 5'd31, 6'd63);
        n_cmp++; if (dispatch_ready !== 1'b0 || commit_opcode !== 7'h10) begin n_fail++;
            $display("FAIL full_17th_ignored: got rdy %b op %h want rdy 0 op 10",
                     dispatch_ready, commit_opcode); end
        do_wb(4'd0, 1'b0, 32'h0);
        // Pop with a dispatch attempt while full: pop happens, allocation does not.
        dispatch_valid  = 1'b1;
        dispatch_opcode = 7'h7e;
        rob_pop         = 1'b1;
        tick();
        dispatch_valid  = 1'b0;
        rob_pop         = 1'b0;
        n_cmp++; if (dispatch_ready !== 1'b1 || dispatch_idx !== 4'd0 || commit_opcode !== 7'h11)
        begin n_fail++;
            $display("FAIL full_pop_wrap: got rdy %b idx %0d op %h want rdy 1 idx 0 op 11",
                     dispatch_ready, dispatch_idx, commit_opcode); end
        do_dispatch(7'h7d, 5'd0, 6'd0);
        n_cmp++; if (dispatch_ready !== 1'b0 || dispatch_idx !== 4'd1) begin n_fail++;
            $display("FAIL full_refill: got rdy %b idx %0d want rdy 0 idx 1",
                     dispatch_ready, dispatch_idx); end
    endtask

    task automatic test_steady();
        do_flush();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            do_dispatch(7'(8'h40 + i), 5'(i), 6'(i));
            exp_q.push_back(7'(8'h40 + i));
        end
        for (int i = 0; i < 4; i++) do_wb(4'(i), 1'b0, 32'h0);
        for (int k = 0; k < 40; k++) begin
            n_cmp++; if (rob_ready !== 1'b1 || dispatch_ready !== 1'b1) begin n_fail++;
                $display("FAIL steady_ready_%0d: got r%b drdy %b want 1 1",
                         k, rob_ready, dispatch_ready); end
            n_cmp++; if (commit_opcode !== exp_q[0]) begin n_fail++;
                $display("FAIL steady_head_%0d: got %h want %h", k, commit_opcode, exp_q[0]); end
            n_cmp++; if (dispatch_idx !== 4'((4 + k) % 16)) begin n_fail++;
                $display("FAIL steady_tail_%0d: got %0d want %0d", k, dispatch_idx, (4 + k) % 16); end
            dispatch_valid  = 1'b1;
            dispatch_opcode = 7'(8'h50 + k);
            rob_pop         = 1'b1;
            // Complete the entry allocated on the previous cycle.
            cdb_valid       = 1'b1;
            cdb_idx         = 4'((3 + k) % 16);
            tick();
            exp_q.push_back(7'(8'h50 + k));
            void'(exp_q.pop_front());
        end
        idle_inputs();
        n_cmp++; if (rob_valid !== 1'b1 || dispatch_idx !== 4'd12 || commit_opcode !== 7'h74) begin
            n_fail++;
            $display("FAIL steady_end: got v%b idx %0d op %h want v1 idx 12 op 74",
                     rob_valid, dispatch_idx, commit_opcode); end
    endtask

    task automatic test_branch();
        do_flush();
        do_dispatch(7'h33, 5'd5, 6'd20);
        do_dispatch(7'h63, 5'd0, 6'd0);
        do_dispatch(7'h13, 5'd6, 6'd21);
        do_wb(4'd0, 1'b0, 32'h0);
        do_pop();
        n_cmp++; if (flush_branch !== 1'b0 || rob_ready !== 1'b0 || commit_opcode !== 7'h63) begin
            n_fail++;
            $display("FAIL br_before_wb: got fb %b r%b op %h want 0 0 63",
                     flush_branch, rob_ready, commit_opcode); end
        do_wb(4'd1, 1'b1, 32'h8000_0040);
        n_cmp++; if (flush_branch !== 1'b1 || rob_ready !== 1'b1) begin n_fail++;
            $display("FAIL br_flush_branch: got fb %b r%b want 1 1", flush_branch, rob_ready); end
        n_cmp++; if (commit_target !== 32'h8000_0040) begin n_fail++;
            $display("FAIL br_target: got %h want 80000040", commit_target); end
        // Pop + flush with a competing dispatch: flush wins and the ROB empties.
        rob_pop         = 1'b1;
        flush           = 1'b1;
        dispatch_valid  = 1'b1;
        dispatch_opcode = 7'h6f;
        tick();
        idle_inputs();
        n_cmp++; if (rob_valid !== 1'b0 || dispatch_idx !== 4'd0 || flush_branch !== 1'b0 ||
                     dispatch_ready !== 1'b1) begin n_fail++;
            $display("FAIL br_flush_empty: got v%b idx %0d fb %b rdy %b want v0 idx 0 fb 0 rdy 1",
                     rob_valid, dispatch_idx, flush_branch, dispatch_ready); end
        do_dispatch(7'h13, 5'd7, 6'd22);
        n_cmp++; if (rob_valid !== 1'b1 || rob_ready !== 1'b0 || commit_opcode !== 7'h13) begin
            n_fail++;
            $display("FAIL br_after_flush: got v%b r%b op %h want v1 r0 op 13",
                     rob_valid, rob_ready, commit_opcode); end
    endtask

    task automatic test_async_reset();
        do_flush();
        for (int i = 0; i < 5; i++) do_dispatch(7'(8'h30 + i), 5'(i), 6'(i));
        do_wb(4'd0, 1'b0, 32'h0);
        n_cmp++; if (rob_valid !== 1'b1 || dispatch_idx !== 4'd5 || rob_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got v%b idx %0d r%b want v1 idx 5 r1",
                     rob_valid, dispatch_idx, rob_ready); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rob_valid !== 1'b0 || rob_ready !== 1'b0 || dispatch_idx !== 4'd0 ||
                     dispatch_ready !== 1'b1 || commit_opcode !== 7'h00) begin n_fail++;
            $display("FAIL arst_async: got v%b r%b idx %0d rdy %b op %h want v0 r0 idx 0 rdy 1 op 0",
                     rob_valid, rob_ready, dispatch_idx, dispatch_ready, commit_opcode); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (rob_valid !== 1'b0 || dispatch_idx !== 4'd0) begin n_fail++;
            $display("FAIL arst_post: got v%b idx %0d want v0 idx 0", rob_valid, dispatch_idx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_steady();
        test_branch();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
